// File: rtl/tx_framer.sv
// tx_framer: gathers PKT_BYTES payload bytes from the SPI slave, then sends
// preamble, payload (arrival order, MSB first) and an XOR checksum byte on
// tx_out, one bit per bit_en strobe.
module tx_framer #(
    parameter int          PKT_BYTES  = 3,
    parameter int          PRE_BITS   = 8,
    parameter logic [15:0] PREAMBLE   = 16'h00AA,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic       bit_en,
    output logic       tx_out,
    output logic       busy,
    output logic       done,
    output logic       overflow
);

    localparam int CNT_W   = $clog2(PKT_BYTES + 1);
    localparam int IDX_MAX = (PRE_BITS > 8) ? PRE_BITS : 8;
    localparam int BIT_W   = $clog2(IDX_MAX);
    localparam int BUF_W   = 8 * PKT_BYTES;

    localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(PKT_BYTES);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(PKT_BYTES - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [BIT_W-1:0]      PRE_TOP  = BIT_W'(PRE_BITS - 1);
    localparam logic [BIT_W-1:0]      BYTE_TOP = BIT_W'(7);
    localparam logic [2**BIT_W-1:0]   PRE_PAT  = PREAMBLE[2**BIT_W-1:0];

    typedef enum logic [1:0] {
        S_COLLECT,
        S_PREAMBLE,
        S_DATA,
        S_CHECK
    } state_t;

    state_t           state_q, state_d;
    // Bytes stored while collecting; bytes still to send while in DATA.
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [BIT_W-1:0] bit_q,   bit_d;
    logic [7:0]       chk_q,   chk_d;
    logic [BUF_W-1:0] buf_q,   buf_d;
    logic             tx_q,    tx_d;
    logic             done_q,  done_d;
    logic             ovf_q,   ovf_d;

    logic             accept;
    logic [BIT_W-1:0] bit_dec;

    assign byte_ready = (state_q == S_COLLECT) && (cnt_q != CNT_FULL);
    assign accept     = byte_valid && byte_ready;
    assign bit_dec    = bit_q - 1'b1;

    assign tx_out   = tx_q;
    assign busy     = (state_q != S_COLLECT);
    assign done     = done_q;
    assign overflow = ovf_q;

    // Next-state and output logic. The payload buffer is a shift register:
    // bytes enter at the bottom, so the first byte ends up at the top and
    // the DATA phase simply shifts it out MSB first.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        chk_d   = chk_q;
        buf_d   = buf_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q | (byte_valid & ~byte_ready);

        case (state_q)
            S_COLLECT: begin
                tx_d = IDLE_LEVEL;
                if (accept) begin
                    buf_d      = buf_q << 8;
                    buf_d[7:0] = byte_in;
                    cnt_d      = cnt_q + 1'b1;
                    chk_d      = chk_q ^ byte_in;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_PREAMBLE;
                        bit_d   = PRE_TOP;
                        tx_d    = PRE_PAT[PRE_TOP];
                    end
                end
            end

            S_PREAMBLE: begin
                if (bit_en) begin
                    if (bit_q == '0) begin
                        state_d = S_DATA;
                        bit_d   = BYTE_TOP;
                        tx_d    = buf_q[BUF_W-1];
                    end else begin
                        bit_d = bit_dec;
                        tx_d  = PRE_PAT[bit_dec];
                    end
                end
            end

            S_DATA: begin
                if (bit_en) begin
                    if (bit_q == '0 && cnt_q == CNT_ONE) begin
                        state_d = S_CHECK;
                        bit_d   = BYTE_TOP;
                        tx_d    = chk_q[7];
                    end else begin
                        buf_d = buf_q << 1;
                        tx_d  = buf_q[BUF_W-2];
                        if (bit_q == '0) begin
                            bit_d = BYTE_TOP;
                            cnt_d = cnt_q - 1'b1;
                        end else begin
                            bit_d = bit_dec;
                        end
                    end
                end
            end

            S_CHECK: begin
                if (bit_en) begin
                    if (bit_q == '0) begin
                        state_d = S_COLLECT;
                        tx_d    = IDLE_LEVEL;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        chk_d   = '0;
                    end else begin
                        chk_d = chk_q << 1;
                        tx_d  = chk_q[6];
                        bit_d = bit_dec;
                    end
                end
            end

            default: begin
                state_d = S_COLLECT;
                tx_d    = IDLE_LEVEL;
            end
        endcase
    end

    // Control registers with synchronous reset; reset abandons any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_COLLECT;
            cnt_q   <= '0;
            bit_q   <= '0;
            chk_q   <= '0;
            tx_q    <= IDLE_LEVEL;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            chk_q   <= chk_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    // Payload buffer: pure data, its content only matters once the count is full.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

endmodule

// File: tb/tb_tx_framer.sv
// Testbench for tx_framer: random and directed stimulus, a frame-level
// reference model, and a scoreboard monitor that checks each transmitted bit.
module tb_tx_framer;

    localparam int          PKT     = 3;
    localparam int          PRE     = 8;
    localparam logic [15:0] PRE_PAT = 16'h00AA;
    localparam logic        IDLE    = 1'b0;
    localparam int          FRAME   = PRE + 8 * PKT + 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic       bit_en;
    logic       tx_out;
    logic       busy;
    logic       done;
    logic       overflow;

    int n_chk  = 0;
    int n_fail = 0;

    // Scoreboard: expected serial bits and per-frame lengths.
    bit exp_bits[$];
    int exp_len[$];

    // Reference model state.
    logic [7:0] pend[$];
    int         rem     = 0;
    bit         m_ovf   = 0;
    int         mode    = 0;   // 0: bit_en always, 1: one cycle in 4, 2: random
    int         phase   = 0;
    int         lat_p   = 0;
    int         cyc     = 0;
    int         acc_cyc = 0;

    tx_framer #(
        .PKT_BYTES (PKT),
        .PRE_BITS  (PRE),
        .PREAMBLE  (PRE_PAT),
        .IDLE_LEVEL(IDLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .bit_en    (bit_en),
        .tx_out    (tx_out),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Build the full expected frame from the collected payload.
    task automatic push_frame();
        logic [7:0] x;
        x = 8'h00;
        for (int i = PRE - 1; i >= 0; i--) exp_bits.push_back(PRE_PAT[i]);
        foreach (pend[k]) begin
            x = x ^ pend[k];
            for (int b = 7; b >= 0; b--) exp_bits.push_back(pend[k][b]);
        end
        for (int b = 7; b >= 0; b--) exp_bits.push_back(x[b]);
        exp_len.push_back(FRAME);
    endtask

    // One clock: update the model with what was driven, check control outputs,
    // then drive defaults for the next cycle.
    task automatic tick();
        bit dn;
        bit commit;
        dn     = 1'b0;
        commit = 1'b0;
        @(posedge clk);
        if (rst) begin
            rem   = 0;
            m_ovf = 1'b0;
            pend.delete();
            exp_bits.delete();
            exp_len.delete();
        end else if (rem > 0) begin
            if (byte_valid) m_ovf = 1'b1;
            if (bit_en) begin
                rem--;
                dn = (rem == 0);
            end
        end else if (byte_valid) begin
            pend.push_back(byte_in);
            if (pend.size() == PKT) begin
                push_frame();
                pend.delete();
                rem     = FRAME;
                commit  = 1'b1;
                acc_cyc = cyc + 1;
            end
        end
        #1;
        cyc++;
        check("busy", busy, (rem > 0));
        check("byte_ready", byte_ready, (rem == 0));
        check("overflow", overflow, m_ovf);
        check("done", done, dn);
        if (rem == 0) check("tx_idle", tx_out, IDLE);
        if (commit) check("first_bit", tx_out, PRE_PAT[PRE-1]);
        if (dn && lat_p != 0) check("frame_cycles", cyc - acc_cyc, FRAME * lat_p);
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
        rst        = 1'b0;
        if (commit) phase = 0;
        phase++;
        case (mode)
            0:       bit_en = 1'b1;
            1:       bit_en = (phase % 4 == 0);
            default: bit_en = 1'($urandom);
        endcase
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_in    = b;
        tick();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (rem > 0 && n < 5000) begin
            tick();
            n++;
        end
        if (rem > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_idle: frame still running after %0d cycles, expected completion", n);
        end
    endtask

    // Monitor: each bit consumed by a bit_en strobe is compared with the
    // scoreboard; each done pulse closes one frame.
    initial begin
        int seen;
        seen = 0;
        forever begin
            @(negedge clk);
            if (busy && bit_en) begin
                if (exp_bits.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL tx_bit: got %0b with no bit expected (t=%0t)", tx_out, $time);
                end else begin
                    check("tx_bit", tx_out, exp_bits.pop_front());
                    seen++;
                end
            end
            if (done) begin
                if (exp_len.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL frame_end: got done with no frame expected (t=%0t)", $time);
                end else begin
                    check("frame_len", seen, exp_len.pop_front());
                end
                seen = 0;
            end
            if (rst) seen = 0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        bit_en     = 1'b0;

        // Reset
        rst = 1'b1; tick();
        rst = 1'b1; tick();

        // Basic frame, bit_en held high
        mode = 0; lat_p = 1; tick();
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        wait_idle();
        tick();

        // Stalled bit rate, one strobe in four
        mode = 1; lat_p = 4; tick();
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        wait_idle();
        tick();

        // Overflow during preamble, then a clean frame
        mode = 0; lat_p = 1; tick();
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        tick(); tick(); tick();
        send_byte(8'hFF);
        wait_idle();
        check("overflow_sticky", overflow, 1'b1);
        send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h3C);
        wait_idle();
        tick();

        // Back-to-back: next frame starts in the done cycle
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        wait_idle();
        check("done_cycle", done, 1'b1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        wait_idle();
        tick();

        // Reset while byte 0x34 bit 5 is on the line
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        for (int i = 0; i < 18; i++) tick();
        rst = 1'b1; tick();
        check("rst_tx", tx_out, IDLE);
        check("rst_overflow", overflow, 1'b0);
        send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE);
        wait_idle();
        tick();

        // Partial fill with bit_en toggling
        mode = 2; lat_p = 0; tick();
        send_byte(8'h77); tick(); send_byte(8'h88);
        for (int i = 0; i < 60; i++) tick();
        check("partial_busy", busy, 1'b0);
        send_byte(8'h99);
        wait_idle();
        tick();

        // Randomized traffic, including bytes offered while busy
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(3) == 0) send_byte(8'($urandom));
            else tick();
        end
        wait_idle();
        tick(); tick();
        check("scoreboard_empty", exp_bits.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
